fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter PC_RESET, default 16'h0000: program counter value after reset.
REQ-002 Parameter MFC_TIMEOUT, default 255: maximum cycles to wait for MFC before the block faults.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Port run, input, 1: enables fetching while high.
REQ-006 Port MFC, input, 1: memory-function-complete strobe from memory.
REQ-007 Port memData, input, 16: instruction word from memory, valid while MFC is high.
REQ-008 Port fetch, input, 1: pulse from the execute FSM that the current instruction is finished.
REQ-009 Port incr, input, 1: pulse from the execute FSM requesting an extra PC increment (operand word consumed).
REQ-010 Port MemEN, output, 1: memory request enable.
REQ-011 Port RW, output, 1: read/write select; 1 = read; this block only reads.
REQ-012 Port address, output, 16: fetch address; always driven (not tri-state).
REQ-013 Port start, output, 1: one-cycle pulse handing a decoded instruction to the execute FSM.
REQ-014 Port opCode, output, 4: decoded opcode, IR[15:12].
REQ-015 Port para1, output, 6: decoded first operand, IR[11:6].
REQ-016 Port para2, output, 6: decoded second operand, IR[5:0].
REQ-017 Port pc, output, 16: current program counter.
REQ-018 Port err, output, 1: sticky fault flag for an MFC timeout.

Function
REQ-019 The state machine SHALL use the states IDLE, REQ, WAIT, DECODE, ISSUE, EXEC, HALT and FAULT.
REQ-020 IDLE->REQ when run=1; otherwise stay in IDLE.
REQ-021 REQ drives MemEN=1, RW=1 and address=pc for exactly one cycle, then moves to WAIT.
REQ-022 WAIT holds MemEN=1, RW=1 and address=pc.
REQ-023 In WAIT, MFC=1 captures memData into IR and moves to DECODE.
REQ-024 The WAIT cycle counter resets on entry to WAIT; when it reaches MFC_TIMEOUT with no MFC, the block moves to FAULT and sets err=1.
REQ-025 DECODE registers opCode, para1 and para2 from IR, sets pc=pc+1 (wrapping FFFF->0000), then moves to ISSUE.
REQ-026 DECODE moves to HALT instead of ISSUE when IR[15:12]=4'hF.
REQ-027 ISSUE asserts start for exactly one cycle, then moves to EXEC.
REQ-028 opCode, para1 and para2 SHALL hold stable from DECODE until the next DECODE.
REQ-029 In EXEC, each cycle with incr=1 increments pc by 1, with wrap-around.
REQ-030 In EXEC, fetch=1 moves to REQ when run=1 and to IDLE when run=0.
REQ-031 When incr and fetch are high in the same cycle, the pc increment SHALL apply and the transition SHALL also occur; the next REQ uses the incremented pc.
REQ-032 incr and fetch outside EXEC SHALL be ignored.
REQ-033 MFC outside WAIT SHALL be ignored.
REQ-034 HALT and FAULT SHALL be terminal until reset; in both, MemEN=0 and start=0.
REQ-035 Deasserting run in REQ, WAIT, DECODE, ISSUE or EXEC SHALL NOT abort the cycle in progress; run is checked only in IDLE and on fetch.
REQ-036 MemEN=0 in every state except REQ and WAIT; in those states address SHALL equal pc, and address is 0 elsewhere.

Reset
REQ-037 reset=0 at a rising clk edge SHALL force state=IDLE, pc=PC_RESET, IR=0, opCode/para1/para2=0, start=0, MemEN=0, RW=1, err=0 and the timeout counter to 0.
REQ-038 Reset SHALL take priority over every other input in every state, including a transaction that is mid-WAIT.

Structure
REQ-039 A shared package SHALL hold the state enumeration, the opcode field positions and the HALT opcode constant 4'hF.
REQ-040 The WAIT timeout counter SHALL be one sub-module, mfc_timer, with ports clear, enable and expired.
REQ-041 All outputs SHALL come from registers; there are no latches and no tri-states.

Verification
REQ-042 Reset, then run=1, then MFC=1 with memData=16'h1A85 at the 3rd WAIT cycle -> address=0000 during REQ/WAIT, then opCode=1, para1=6'h2A, para2=6'h05, pc=0001, and one start pulse.
REQ-043 In EXEC, pulse incr twice, then fetch -> pc=0003 and the next REQ has address=0003.
REQ-044 incr and fetch in the same cycle with pc=0005 -> next address=0006.
REQ-045 MFC never asserted -> err=1 exactly MFC_TIMEOUT cycles after WAIT entry, and MemEN=0 afterward.
REQ-046 memData=16'hF000 -> HALT: no start pulse, MemEN stays 0, pc=0001.
REQ-047 reset=0 mid-WAIT with pc=0004 -> next cycle state=IDLE, pc=0000 and MemEN=0; a late MFC is ignored.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg: shared state encoding, instruction field layout and helpers
// for the fetch/decode front end.
package fetch_decode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DECODE,
        ISSUE,
        EXEC,
        HALT,
        FAULT
    } state_e;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int P1_MSB = 11;
    localparam int P1_LSB = 6;
    localparam int P2_MSB = 5;
    localparam int P2_LSB = 0;

    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic [3:0] opcode_of(input logic [15:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [5:0] para1_of(input logic [15:0] w);
        return w[P1_MSB:P1_LSB];
    endfunction

    function automatic logic [5:0] para2_of(input logic [15:0] w);
        return w[P2_MSB:P2_LSB];
    endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// fetch_decode_if: instruction-memory read bus.
//   MemEN   request enable (requester -> memory)
//   RW      1 = read       (requester -> memory)
//   address fetch address  (requester -> memory)
//   MFC     memory-function-complete strobe (memory -> requester)
//   memData instruction word, valid while MFC is high (memory -> requester)
interface fetch_decode_if;
    logic        MemEN;
    logic        RW;
    logic [15:0] address;
    logic        MFC;
    logic [15:0] memData;

    modport master (output MemEN, RW, address, input MFC, memData);
    modport slave  (input MemEN, RW, address, output MFC, memData);
endinterface

// File: rtl/fetch_decode_mfc_timer.sv
// mfc_timer: counts cycles spent waiting for MFC.
//   clk, reset   clock and synchronous active-low reset
//   clear        zero the count (asserted the cycle before WAIT is entered)
//   enable       count this cycle (in WAIT with no MFC)
//   expired      high on the LIMIT-th enabled cycle since the last clear
module mfc_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_d   = clear ? '0 : enable ? cnt_q + W'(1) : cnt_q;
    // Count is k-1 during the k-th waiting cycle, so this fires on cycle LIMIT.
    assign expired = enable && (cnt_q == W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch and decode front end for a simple CPU.
//   clk, reset           clock and synchronous active-low reset
//   run                  enables fetching (sampled in IDLE and on fetch)
//   fetch                execute FSM finished the current instruction
//   incr                 execute FSM consumed an operand word (pc + 1)
//   mem                  memory read bus (master side)
//   start                one-cycle pulse: decoded instruction is ready
//   opCode, para1, para2 decoded instruction fields
//   pc                   program counter
//   err                  sticky MFC-timeout fault
module fetch_decode
    import fetch_decode_pkg::*;
#(
    parameter logic [15:0] PC_RESET    = 16'h0000,
    parameter int          MFC_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  fetch,
    input  logic                  incr,
    fetch_decode_if.master        mem,
    output logic                  start,
    output logic [3:0]            opCode,
    output logic [5:0]            para1,
    output logic [5:0]            para2,
    output logic [15:0]           pc,
    output logic                  err
);
    state_e      state_q;
    logic [15:0] pc_q, ir_q, addr_q;
    logic [3:0]  opcode_q;
    logic [5:0]  para1_q, para2_q;
    logic        start_q, mem_en_q, rw_q, err_q;
    logic        expired;
    logic [15:0] pc_inc;

    assign pc_inc = pc_q + 16'd1;

    mfc_timer #(.LIMIT(MFC_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == REQ),
        .enable  (state_q == WAIT && !mem.MFC),
        .expired (expired)
    );

    // Bus outputs are registered on the transition into the state that owns
    // them, so they line up exactly with REQ/WAIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= PC_RESET;
            ir_q     <= '0;
            opcode_q <= '0;
            para1_q  <= '0;
            para2_q  <= '0;
            start_q  <= 1'b0;
            mem_en_q <= 1'b0;
            rw_q     <= 1'b1;
            addr_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: if (run) begin
                    state_q  <= REQ;
                    mem_en_q <= 1'b1;
                    addr_q   <= pc_q;
                end
                REQ: state_q <= WAIT;
                WAIT: if (mem.MFC) begin
                    ir_q     <= mem.memData;
                    state_q  <= DECODE;
                    mem_en_q <= 1'b0;
                    addr_q   <= '0;
                end else if (expired) begin
                    state_q  <= FAULT;
                    err_q    <= 1'b1;
                    mem_en_q <= 1'b0;
                    addr_q   <= '0;
                end
                DECODE: begin
                    opcode_q <= opcode_of(ir_q);
                    para1_q  <= para1_of(ir_q);
                    para2_q  <= para2_of(ir_q);
                    pc_q     <= pc_inc;
                    state_q  <= opcode_of(ir_q) == OP_HALT ? HALT : ISSUE;
                    start_q  <= opcode_of(ir_q) != OP_HALT;
                end
                ISSUE: state_q <= EXEC;
                EXEC: begin
                    if (incr) pc_q <= pc_inc;
                    // A same-cycle incr must already be visible on the next request.
                    if (fetch) begin
                        state_q  <= run ? REQ : IDLE;
                        mem_en_q <= run;
                        addr_q   <= run ? (incr ? pc_inc : pc_q) : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.MemEN   = mem_en_q;
    assign mem.RW      = rw_q;
    assign mem.address = addr_q;
    assign start       = start_q;
    assign opCode      = opcode_q;
    assign para1       = para1_q;
    assign para2       = para2_q;
    assign pc          = pc_q;
    assign err         = err_q;
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed self-checking bench for fetch_decode.
module tb_fetch_decode;
    import fetch_decode_pkg::*;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset, run, fetch, incr, start, err;
    logic [3:0]  opCode;
    logic [5:0]  para1, para2;
    logic [15:0] pc;
    int          checks = 0;
    int          errors = 0;

    fetch_decode_if bus();

    fetch_decode #(.PC_RESET(16'h0000), .MFC_TIMEOUT(TO)) dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .fetch  (fetch),
        .incr   (incr),
        .mem    (bus),
        .start  (start),
        .opCode (opCode),
        .para1  (para1),
        .para2  (para2),
        .pc     (pc),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        run = 1'b0;
        fetch = 1'b0;
        incr = 1'b0;
        bus.MFC = 1'b0;
        bus.memData = 16'h0000;
        tick;
        tick;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state got %0d want %0d", dut.state_q, IDLE); end
        checks++; if ({bus.MemEN, bus.RW, bus.address} !== {1'b0, 1'b1, 16'h0000}) begin errors++; $display("FAIL rst_bus got %b/%b/%h want 0/1/0000", bus.MemEN, bus.RW, bus.address); end
        checks++; if ({pc, err, start} !== {16'h0000, 1'b0, 1'b0}) begin errors++; $display("FAIL rst_regs got pc=%h err=%b start=%b want 0000/0/0", pc, err, start); end
        checks++; if ({opCode, para1, para2} !== 16'h0000) begin errors++; $display("FAIL rst_fields got %h/%h/%h want 0/0/0", opCode, para1, para2); end
        tick;
        checks++; if (dut.state_q !== IDLE || bus.MemEN !== 1'b0) begin errors++; $display("FAIL idle_norun got state=%0d memen=%b want IDLE/0", dut.state_q, bus.MemEN); end
    endtask

    task automatic test_fetch;
        run = 1'b1;
        tick;
        checks++; if (dut.state_q !== REQ || {bus.MemEN, bus.RW, bus.address} !== {1'b1, 1'b1, 16'h0000}) begin errors++; $display("FAIL req_bus got state=%0d %b/%b/%h want REQ 1/1/0000", dut.state_q, bus.MemEN, bus.RW, bus.address); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL req_start got %b want 0", start); end
        tick;
        checks++; if (dut.state_q !== WAIT || {bus.MemEN, bus.address} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL wait1 got state=%0d %b/%h want WAIT 1/0000", dut.state_q, bus.MemEN, bus.address); end
        incr = 1'b1;
        fetch = 1'b1;
        tick;
        checks++; if (dut.state_q !== WAIT || pc !== 16'h0000) begin errors++; $display("FAIL wait_ignore got state=%0d pc=%h want WAIT/0000", dut.state_q, pc); end
        incr = 1'b0;
        fetch = 1'b0;
        tick;
        checks++; if (dut.state_q !== WAIT || bus.MemEN !== 1'b1) begin errors++; $display("FAIL wait3 got state=%0d memen=%b want WAIT/1", dut.state_q, bus.MemEN); end
        bus.MFC = 1'b1;
        bus.memData = 16'h1A85;
        tick;
        checks++; if (dut.state_q !== DECODE || {bus.MemEN, bus.address, start} !== {1'b0, 16'h0000, 1'b0}) begin errors++; $display("FAIL decode got state=%0d %b/%h start=%b want DECODE 0/0000/0", dut.state_q, bus.MemEN, bus.address, start); end
        bus.MFC = 1'b0;
        bus.memData = 16'hFFFF;
        tick;
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL issue_start got %b want 1", start); end
        checks++; if ({opCode, para1, para2} !== {4'h1, 6'h2A, 6'h05}) begin errors++; $display("FAIL issue_fields got %h/%h/%h want 1/2a/05", opCode, para1, para2); end
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL issue_pc got %h want 0001", pc); end
        tick;
        checks++; if (dut.state_q !== EXEC || start !== 1'b0 || opCode !== 4'h1) begin errors++; $display("FAIL exec got state=%0d start=%b op=%h want EXEC/0/1", dut.state_q, start, opCode); end
    endtask

    task automatic test_incr;
        incr = 1'b1;
        tick;
        checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL incr1 got %h want 0002", pc); end
        incr = 1'b0;
        tick;
        checks++; if (pc !== 16'h0002 || dut.state_q !== EXEC) begin errors++; $display("FAIL incr_gap got pc=%h state=%0d want 0002/EXEC", pc, dut.state_q); end
        incr = 1'b1;
        tick;
        incr = 1'b0;
        fetch = 1'b1;
        tick;
        fetch = 1'b0;
        checks++; if (dut.state_q !== REQ || {bus.MemEN, bus.address, pc} !== {1'b1, 16'h0003, 16'h0003}) begin errors++; $display("FAIL incr_req got state=%0d %b/%h pc=%h want REQ 1/0003 pc=0003", dut.state_q, bus.MemEN, bus.address, pc); end
        tick;
        bus.MFC = 1'b1;
        bus.memData = 16'h2041;
        tick;
        bus.MFC = 1'b0;
        tick;
        checks++; if ({start, opCode, para1, para2, pc} !== {1'b1, 4'h2, 6'h01, 6'h01, 16'h0004}) begin errors++; $display("FAIL second_issue got start=%b %h/%h/%h pc=%h want 1 2/01/01 pc=0004", start, opCode, para1, para2, pc); end
        tick;
    endtask

    task automatic test_reset_mid_wait;
        fetch = 1'b1;
        tick;
        fetch = 1'b0;
        checks++; if ({bus.MemEN, bus.address} !== {1'b1, 16'h0004}) begin errors++; $display("FAIL req4 got %b/%h want 1/0004", bus.MemEN, bus.address); end
        tick;
        tick;
        checks++; if (dut.state_q !== WAIT || pc !== 16'h0004) begin errors++; $display("FAIL pre_reset got state=%0d pc=%h want WAIT/0004", dut.state_q, pc); end
        reset = 1'b0;
        bus.MFC = 1'b1;
        bus.memData = 16'h5555;
        tick;
        checks++; if (dut.state_q !== IDLE || {pc, bus.MemEN, bus.address, opCode} !== {16'h0000, 1'b0, 16'h0000, 4'h0}) begin errors++; $display("FAIL mid_wait_reset got state=%0d pc=%h memen=%b addr=%h op=%h want IDLE 0000/0/0000/0", dut.state_q, pc, bus.MemEN, bus.address, opCode); end
        reset = 1'b1;
        run = 1'b0;
        tick;
        checks++; if (dut.state_q !== IDLE || {pc, bus.MemEN} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL late_mfc got state=%0d pc=%h memen=%b want IDLE/0000/0", dut.state_q, pc, bus.MemEN); end
        bus.MFC = 1'b0;
    endtask

    task automatic test_back_to_back;
        run = 1'b1;
        tick;
        tick;
        bus.MFC = 1'b1;
        bus.memData = 16'h3000;
        tick;
        bus.MFC = 1'b0;
        tick;
        checks++; if ({start, opCode, pc} !== {1'b1, 4'h3, 16'h0001}) begin errors++; $display("FAIL b2b_issue got start=%b op=%h pc=%h want 1/3/0001", start, opCode, pc); end
        tick;
        incr = 1'b1;
        repeat (4) tick;
        checks++; if (pc !== 16'h0005) begin errors++; $display("FAIL b2b_pc5 got %h want 0005", pc); end
        fetch = 1'b1;
        tick;
        incr = 1'b0;
        fetch = 1'b0;
        run = 1'b0;
        checks++; if (dut.state_q !== REQ || {bus.MemEN, bus.address, pc} !== {1'b1, 16'h0006, 16'h0006}) begin errors++; $display("FAIL same_cycle got state=%0d %b/%h pc=%h want REQ 1/0006 pc=0006", dut.state_q, bus.MemEN, bus.address, pc); end
        tick;
        checks++; if (dut.state_q !== WAIT || {bus.MemEN, bus.address} !== {1'b1, 16'h0006}) begin errors++; $display("FAIL run_low_wait got state=%0d %b/%h want WAIT 1/0006", dut.state_q, bus.MemEN, bus.address); end
        bus.MFC = 1'b1;
        bus.memData = 16'h4000;
        tick;
        bus.MFC = 1'b0;
        tick;
        checks++; if ({start, opCode, pc} !== {1'b1, 4'h4, 16'h0007}) begin errors++; $display("FAIL run_low_issue got start=%b op=%h pc=%h want 1/4/0007", start, opCode, pc); end
        tick;
        fetch = 1'b1;
        tick;
        fetch = 1'b0;
        checks++; if (dut.state_q !== IDLE || {bus.MemEN, bus.address} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL fetch_idle got state=%0d %b/%h want IDLE 0/0000", dut.state_q, bus.MemEN, bus.address); end
    endtask

    task automatic test_halt;
        int bad;
        bad = 0;
        do_reset;
        run = 1'b1;
        tick;
        tick;
        bus.MFC = 1'b1;
        bus.memData = 16'hF000;
        tick;
        bus.MFC = 1'b0;
        tick;
        checks++; if (dut.state_q !== HALT || {start, bus.MemEN, pc, opCode} !== {1'b0, 1'b0, 16'h0001, 4'hF}) begin errors++; $display("FAIL halt got state=%0d start=%b memen=%b pc=%h op=%h want HALT 0/0/0001/f", dut.state_q, start, bus.MemEN, pc, opCode); end
        fetch = 1'b1;
        incr = 1'b1;
        bus.MFC = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (start !== 1'b0 || bus.MemEN !== 1'b0 || pc !== 16'h0001) bad++;
        end
        fetch = 1'b0;
        incr = 1'b0;
        bus.MFC = 1'b0;
        checks++; if (bad !== 0 || dut.state_q !== HALT) begin errors++; $display("FAIL halt_hold got bad_cycles=%0d state=%0d want 0/HALT", bad, dut.state_q); end
    endtask

    task automatic test_timeout;
        int early;
        early = 0;
        do_reset;
        run = 1'b1;
        tick;
        tick;
        checks++; if (dut.state_q !== WAIT || err !== 1'b0) begin errors++; $display("FAIL to_entry got state=%0d err=%b want WAIT/0", dut.state_q, err); end
        for (int k = 1; k < TO; k++) begin
            tick;
            if (err !== 1'b0 || bus.MemEN !== 1'b1) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL to_early got %0d bad cycles want 0", early); end
        tick;
        checks++; if (dut.state_q !== FAULT || {err, bus.MemEN, bus.address} !== {1'b1, 1'b0, 16'h0000}) begin errors++; $display("FAIL to_fault got state=%0d err=%b memen=%b addr=%h want FAULT 1/0/0000", dut.state_q, err, bus.MemEN, bus.address); end
        bus.MFC = 1'b1;
        fetch = 1'b1;
        repeat (3) tick;
        bus.MFC = 1'b0;
        fetch = 1'b0;
        checks++; if (dut.state_q !== FAULT || {err, bus.MemEN, start} !== {1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL fault_hold got state=%0d err=%b memen=%b start=%b want FAULT 1/0/0", dut.state_q, err, bus.MemEN, start); end
        do_reset;
        checks++; if (dut.state_q !== IDLE || err !== 1'b0) begin errors++; $display("FAIL fault_clear got state=%0d err=%b want IDLE/0", dut.state_q, err); end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_incr;
        test_reset_mid_wait;
        test_back_to_back;
        test_halt;
        test_timeout;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
